// File: rtl/bimodal_predictor.sv
`default_nettype none
// ============================================================================
// Module   : bimodal_predictor
// Brief    : Table of 2^IDX_W saturating CTR_W-bit direction counters indexed
//            by PC bits; one prediction and one update per cycle. Define
//            GSHARE_EN to XOR a global history register into the index.
// Revision : 1.0 - initial release
// ============================================================================
module bimodal_predictor #(
    parameter int PC_W   = 32,
    parameter int PC_LSB = 2,
    parameter int IDX_W  = 4,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [PC_W-1:0]   req_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic              pred_strong,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [HIST_W-1:0] upd_hist
);

    localparam int               c_DEPTH    = 1 << IDX_W;
    localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] c_CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    logic [CTR_W-1:0] r_ctr [c_DEPTH];

    logic [IDX_W-1:0] w_ridx_pc;
    logic [IDX_W-1:0] w_uidx_pc;
    logic [IDX_W-1:0] w_ridx;
    logic [IDX_W-1:0] w_uidx;
    logic [CTR_W-1:0] w_rd_ctr;
    logic [CTR_W-1:0] w_upd_cur;
    logic [CTR_W-1:0] w_upd_next;

    logic r_pred_valid;
    logic r_pred_taken;
    logic r_pred_strong;

    assign w_ridx_pc = req_pc[PC_LSB+IDX_W-1:PC_LSB];
    assign w_uidx_pc = upd_pc[PC_LSB+IDX_W-1:PC_LSB];

`ifdef GSHARE_EN
    logic [HIST_W-1:0] r_ghr;
    logic [HIST_W-1:0] r_pred_hist;

    assign w_ridx = w_ridx_pc ^ IDX_W'(r_ghr);
    assign w_uidx = w_uidx_pc ^ IDX_W'(upd_hist);

    // Truncating {ghr, taken} to HIST_W bits is the shift-in, valid for HIST_W=1 too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr       <= '0;
            r_pred_hist <= '0;
        end else begin
            if (upd_valid) begin
                r_ghr <= HIST_W'({r_ghr, upd_taken});
            end
            if (req_valid) begin
                r_pred_hist <= r_ghr;
            end
        end
    end

    assign pred_hist = r_pred_hist;
`else
    assign w_ridx    = w_ridx_pc;
    assign w_uidx    = w_uidx_pc;
    assign pred_hist = '0;
`endif

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, req_pc, upd_pc, upd_hist};

    // Prediction reads the current table state, so a same-cycle update is not visible.
    assign w_rd_ctr  = r_ctr[w_ridx];
    assign w_upd_cur = r_ctr[w_uidx];

    always_comb begin
        w_upd_next = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != c_CTR_MAX) begin
                w_upd_next = w_upd_cur + CTR_W'(1);
            end
        end else begin
            if (w_upd_cur != '0) begin
                w_upd_next = w_upd_cur - CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_ctr[i] <= c_CTR_INIT;
            end
        end else if (upd_valid) begin
            r_ctr[w_uidx] <= w_upd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_strong <= 1'b0;
        end else begin
            r_pred_valid <= req_valid;
            if (req_valid) begin
                r_pred_taken  <= w_rd_ctr[CTR_W-1];
                r_pred_strong <= (w_rd_ctr == '0) || (w_rd_ctr == c_CTR_MAX);
            end
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_strong = r_pred_strong;

endmodule
`default_nettype wire

// File: tb/tb_bimodal_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bimodal_predictor
// Brief    : Directed self-checking bench for bimodal_predictor (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bimodal_predictor;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        pred_strong;
    logic [3:0]  pred_hist;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [3:0]  upd_hist;

    int checks = 0;
    int errors = 0;

    bimodal_predictor dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_pc      (req_pc),
        .pred_valid  (pred_valid),
        .pred_taken  (pred_taken),
        .pred_strong (pred_strong),
        .pred_hist   (pred_hist),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_hist    (upd_hist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All stimulus changes land 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        upd_valid = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        tick();
    endtask

    task automatic req(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        tick();
    endtask

    task automatic chk_pred(input string tag, input logic tk, input logic st);
        chk({tag, "_valid"},  pred_valid,  1'b1);
        chk({tag, "_taken"},  pred_taken,  tk);
        chk({tag, "_strong"}, pred_strong, st);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        upd_hist  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  pred_valid,  1'b0);
        chk("rst_taken",  pred_taken,  1'b0);
        chk("rst_strong", pred_strong, 1'b0);
        chk("rst_hist",   pred_hist,   4'h0);
        rst = 1'b0;

        // Fresh counter is weakly not-taken (1).
        req(32'h40);
        chk_pred("init", 1'b0, 1'b0);
        tick();
        chk("idle_valid", pred_valid, 1'b0);
        chk("idle_hold",  pred_taken, 1'b0);

        upd(32'h40, 1'b1);
        req(32'h40);
        chk_pred("ctr2", 1'b1, 1'b0);
        upd(32'h40, 1'b1);
        req(32'h40);
        chk_pred("ctr3", 1'b1, 1'b1);
        // Two more taken must saturate; one not-taken then gives 2, not a wrapped value.
        upd(32'h40, 1'b1);
        upd(32'h40, 1'b1);
        upd(32'h40, 1'b0);
        req(32'h40);
        chk_pred("sat_hi", 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) upd(32'h40, 1'b0);
        req(32'h40);
        chk_pred("ctr0", 1'b0, 1'b1);
        upd(32'h40, 1'b1);
        req(32'h40);
        chk_pred("sat_lo", 1'b0, 1'b0);

        // Index 0 now at 1; train to 3 and probe neighbour and alias.
        upd(32'h40, 1'b1);
        upd(32'h40, 1'b1);
        req(32'h44);
        chk_pred("idx1", 1'b0, 1'b0);
        req(32'h440);
        chk_pred("alias", 1'b1, 1'b1);

        // Back to 1, then simultaneous request and update on the same entry.
        upd(32'h40, 1'b0);
        upd(32'h40, 1'b0);
        req_valid = 1'b1;
        req_pc    = 32'h40;
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b1;
        tick();
        chk_pred("rbw_old", 1'b0, 1'b0);
        req(32'h40);
        chk_pred("rbw_new", 1'b1, 1'b0);

        // Different indices in the same cycle stay independent.
        req_valid = 1'b1;
        req_pc    = 32'h44;
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b1;
        tick();
        chk_pred("indep_req", 1'b0, 1'b0);
        req(32'h40);
        chk_pred("indep_upd", 1'b1, 1'b1);
        tick();
        chk("hold_valid",  pred_valid,  1'b0);
        chk("hold_taken",  pred_taken,  1'b1);
        chk("hold_strong", pred_strong, 1'b1);

        // Mid-stream async reset with a request and update pending.
        req_valid = 1'b1;
        req_pc    = 32'h40;
        upd_valid = 1'b1;
        upd_pc    = 32'h40;
        upd_taken = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_taken",  pred_taken,  1'b0);
        chk("mrst_strong", pred_strong, 1'b0);
        tick();
        chk("mrst_valid", pred_valid, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req(32'(i) << 2);
            chk_pred($sformatf("post_rst_%0d", i), 1'b0, 1'b0);
            chk("post_rst_hist", pred_hist, 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bimodal_predictor.md
Name: bimodal_predictor

Overview:
Parametrised branch direction predictor; successor to the single 2-bit counter block. Holds a table of 2^IDX_W saturating counters of CTR_W bits, indexed by PC bits. Services one prediction request and one resolved-branch update per cycle. Sits between fetch (request side) and execute/retire (update side).

Parameters:
PC_W, 32, width of request/update PC.
PC_LSB, 2, lowest PC bit used for the index (instruction alignment).
IDX_W, 4, index width; table depth = 2^IDX_W entries.
CTR_W, 2, counter width; must be >= 2.
HIST_W, 4, global history width; 1 <= HIST_W <= IDX_W; used only with GSHARE_EN.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous active-high reset.
req_valid  input  1  prediction request this cycle.
req_pc  input  PC_W  PC of the branch to predict.
pred_valid  output  1  one-cycle pulse; prediction outputs valid.
pred_taken  output  1  predicted direction (counter MSB).
pred_strong  output  1  counter at a saturation value (0 or 2^CTR_W-1).
pred_hist  output  HIST_W  history snapshot used for this prediction (zero without GSHARE_EN).
upd_valid  input  1  resolved branch update this cycle.
upd_pc  input  PC_W  PC of the resolved branch.
upd_taken  input  1  actual outcome.
upd_hist  input  HIST_W  pred_hist returned with the branch (ignored without GSHARE_EN).

Behaviour:
- Reset (async, rst=1): every counter = 2^(CTR_W-1)-1 (weakly not-taken; 1 for CTR_W=2); pred_valid=0, pred_taken=0, pred_strong=0, pred_hist=0; GHR=0. Reset mid-operation discards any in-flight request/update.
- Index: ridx = req_pc[PC_LSB+IDX_W-1:PC_LSB]; uidx likewise from upd_pc.
- Prediction: latency 1. On req_valid at edge N: at N+1, pred_valid=1, pred_taken=ctr[ridx][CTR_W-1], pred_strong per saturation rule. No req_valid: pred_valid=0; pred_taken/pred_strong/pred_hist hold their last values.
- Update on upd_valid: taken and ctr<max -> ctr+1; not-taken and ctr>0 -> ctr-1; saturated counters unchanged (no wrap).
- Same cycle, same index, req and upd: prediction returns the pre-update value (read-before-write); the update still lands. Different indices are independent.
- No flow control: one request and one update accepted every cycle; no backpressure.
- Upper PC bits above the index alias; no tags.

Optional Feature:
GSHARE_EN. When defined: HIST_W-bit global history register (GHR). Request index = ridx XOR zero-extended GHR; pred_hist = GHR sampled with the request. Update index = uidx XOR zero-extended upd_hist. On upd_valid, GHR <= {GHR[HIST_W-2:0], upd_taken} (for HIST_W=1, GHR <= upd_taken). When a request and an update occur in the same cycle, the request uses the pre-shift GHR. When not defined: no GHR, pure bimodal indexing, pred_hist tied to 0, upd_hist unused.

Test Plan:
- Reset then req_pc=0x40 -> next cycle pred_valid=1, pred_taken=0, pred_strong=0 (counter 1).
- Three updates taken at pc 0x40, then req 0x40 -> pred_taken=1, pred_strong=1; fourth taken update leaves counter at 3 (no wrap). Four not-taken updates -> counter 0, fifth leaves it at 0.
- Train pc 0x40 taken (x2) and query pc 0x44 and pc 0x440 (index 1 vs index 0 alias with IDX_W=4) -> 0x44 predicts 0; 0x440 predicts 1 (aliasing).
- Counter at 1, same cycle req and upd taken to pc 0x40 -> pred_taken=0 returned; following req -> pred_taken=1.
- Assert rst for one cycle mid-stream after training -> all outputs 0, every entry predicts not-taken, counter 1.
- GSHARE_EN: updates taken, taken, not-taken -> GHR=4'b0110; req pc 0x0 -> pred_hist=6, index 6 read; upd pc 0x0 with upd_hist=6 trains entry 6 only.
